// File: rtl/cube_seq_if.sv
// Operand/result bundle for the time-multiplexed cube engine.
// A triple transfers on (i_vld & o_rdy); a result transfers on (o_vld & i_rdy); both edge-sampled.
`timescale 1ns/1ps
interface cube_seq_if;
  logic        i_vld;
  logic        o_rdy;
  logic [14:0] i_op0;
  logic [14:0] i_op1;
  logic [14:0] i_op2;
  logic [2:0]  i_mask;
  logic        o_vld;
  logic        i_rdy;
  logic [13:0] o_cube0;
  logic [13:0] o_cube1;
  logic [13:0] o_cube2;
  logic        o_busy;

  modport master (
    output i_vld, i_op0, i_op1, i_op2, i_mask, i_rdy,
    input  o_rdy, o_vld, o_cube0, o_cube1, o_cube2, o_busy
  );

  modport slave (
    input  i_vld, i_op0, i_op1, i_op2, i_mask, i_rdy,
    output o_rdy, o_vld, o_cube0, o_cube1, o_cube2, o_busy
  );
endinterface

// File: rtl/cube_seq.sv
// Cube engine: one shared 15x15 multiplier computes square then cube per enabled channel.
// Results hold in DONE until the downstream accepts them.
`timescale 1ns/1ps
module cube_seq (
  input  logic        clk,
  input  logic        rst,
  cube_seq_if.slave   io_bus,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQ   = 2'd1,
    ST_CU   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ch;
  logic [1:0]  w_ch_nxt;
  logic [14:0] r_op0;
  logic [14:0] r_op1;
  logic [14:0] r_op2;
  logic [2:0]  r_mask;
  logic [13:0] r_sq;
  logic [13:0] r_cube0;
  logic [13:0] r_cube1;
  logic [13:0] r_cube2;

  logic        w_rdy;
  logic        w_accept;
  logic        w_sq_we;
  logic        w_cu_we;
  logic [1:0]  w_first_ch;
  logic [1:0]  w_next_ch;
  logic        w_has_next;
  logic [14:0] w_op_sel;
  logic [14:0] w_mul_b;
  logic [15:0] w_rnd;
  logic [15:0] w_prod_hi;

  // i_rdy reaches o_rdy combinationally so DONE can hand off and accept on one edge
  assign w_rdy    = (r_state == ST_IDLE) | ((r_state == ST_DONE) & io_bus.i_rdy);
  assign w_accept = io_bus.i_vld & w_rdy;

  always_comb begin
    w_first_ch = 2'd0;
    if (!io_bus.i_mask[0]) begin
      w_first_ch = io_bus.i_mask[1] ? 2'd1 : 2'd2;
    end
  end

  always_comb begin
    w_has_next = 1'b0;
    w_next_ch  = r_ch;
    case (r_ch)
      2'd0: begin
        if (r_mask[1]) begin
          w_has_next = 1'b1;
          w_next_ch  = 2'd1;
        end else if (r_mask[2]) begin
          w_has_next = 1'b1;
          w_next_ch  = 2'd2;
        end
      end
      2'd1: begin
        if (r_mask[2]) begin
          w_has_next = 1'b1;
          w_next_ch  = 2'd2;
        end
      end
      default: begin
        w_has_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (r_ch)
      2'd0:    w_op_sel = r_op0;
      2'd1:    w_op_sel = r_op1;
      default: w_op_sel = r_op2;
    endcase
  end

  // Shared multiplier; only p[29:14] is ever consumed (SQ takes [29:16], CU takes [27:14])
  assign w_mul_b   = (r_state == ST_CU) ? {1'b0, r_sq} : w_op_sel;
  assign w_rnd     = (r_state == ST_CU) ? 16'h2000 : 16'h8000;
  assign w_prod_hi = 16'(({15'd0, w_op_sel} * {15'd0, w_mul_b} + {14'd0, w_rnd}) >> 14);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ch    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_sq_we     = 1'b0;
    w_cu_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_ch_nxt    = w_first_ch;
          w_state_nxt = (io_bus.i_mask == 3'b000) ? ST_DONE : ST_SQ;
        end
      end
      ST_SQ: begin
        w_sq_we     = 1'b1;
        w_state_nxt = ST_CU;
      end
      ST_CU: begin
        w_cu_we = 1'b1;
        if (w_has_next) begin
          w_ch_nxt    = w_next_ch;
          w_state_nxt = ST_SQ;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (io_bus.i_rdy) begin
          if (w_accept) begin
            w_ch_nxt    = w_first_ch;
            w_state_nxt = (io_bus.i_mask == 3'b000) ? ST_DONE : ST_SQ;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op0   <= 15'd0;
      r_op1   <= 15'd0;
      r_op2   <= 15'd0;
      r_mask  <= 3'd0;
      r_sq    <= 14'd0;
      r_cube0 <= 14'd0;
      r_cube1 <= 14'd0;
      r_cube2 <= 14'd0;
    end else begin
      if (w_accept) begin
        r_op0  <= io_bus.i_op0;
        r_op1  <= io_bus.i_op1;
        r_op2  <= io_bus.i_op2;
        r_mask <= io_bus.i_mask;
        if (!io_bus.i_mask[0]) r_cube0 <= 14'd0;
        if (!io_bus.i_mask[1]) r_cube1 <= 14'd0;
        if (!io_bus.i_mask[2]) r_cube2 <= 14'd0;
      end
      if (w_sq_we) begin
        r_sq <= w_prod_hi[15:2];
      end
      if (w_cu_we) begin
        case (r_ch)
          2'd0:    r_cube0 <= w_prod_hi[13:0];
          2'd1:    r_cube1 <= w_prod_hi[13:0];
          default: r_cube2 <= w_prod_hi[13:0];
        endcase
      end
    end
  end

  assign io_bus.o_rdy   = w_rdy;
  assign io_bus.o_vld   = (r_state == ST_DONE);
  assign io_bus.o_busy  = (r_state != ST_IDLE);
  assign io_bus.o_cube0 = r_cube0;
  assign io_bus.o_cube1 = r_cube1;
  assign io_bus.o_cube2 = r_cube2;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_cube_seq.sv
// Directed bench for cube_seq: latency, truncation, mask skipping, back-pressure and reset.
`timescale 1ns/1ps
module tb_cube_seq;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SQ   = 2'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [41:0] exp_q[$];

  cube_seq_if u_if();

  cube_seq u_dut (
    .clk         (clk),
    .rst         (rst),
    .io_bus      (u_if.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [14:0] a, input logic [14:0] b, input logic [14:0] c,
                      input logic [2:0] m);
    int w;
    w = 0;
    u_if.i_op0  = a;
    u_if.i_op1  = b;
    u_if.i_op2  = c;
    u_if.i_mask = m;
    u_if.i_vld  = 1'b1;
    #1;
    while (!u_if.o_rdy && w < 50) begin
      step();
      w++;
    end
    @(posedge clk);
    #1;
    u_if.i_vld = 1'b0;
  endtask

  // counts cycles from the one after accept until o_vld; busy counts o_busy cycles in that window
  task automatic wait_vld(output int lat, output int busy);
    lat  = 1;
    busy = 0;
    while (!u_if.o_vld && lat < 30) begin
      if (u_if.o_busy) busy++;
      step();
      lat++;
    end
    if (u_if.o_busy) busy++;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    u_if.i_vld  = 1'b0;
    u_if.i_rdy  = 1'b1;
    u_if.i_op0  = 15'd0;
    u_if.i_op1  = 15'd0;
    u_if.i_op2  = 15'd0;
    u_if.i_mask = 3'd0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    n_cmp++; if (u_if.o_vld !== 1'b0) begin n_err++; $display("FAIL reset_o_vld: got %b want 0", u_if.o_vld); end
    n_cmp++; if (u_if.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_o_busy: got %b want 0", u_if.o_busy); end
    n_cmp++; if (u_if.o_rdy !== 1'b1) begin n_err++; $display("FAIL reset_o_rdy: got %b want 1", u_if.o_rdy); end
    n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    n_cmp++;
    if ({u_if.o_cube0, u_if.o_cube1, u_if.o_cube2} !== 42'd0) begin
      n_err++;
      $display("FAIL reset_cubes: got %h %h %h want 0 0 0", u_if.o_cube0, u_if.o_cube1, u_if.o_cube2);
    end
  endtask

  task automatic test_full_mask();
    int lat, busy;
    u_if.i_rdy = 1'b1;
    send(15'h4000, 15'h2000, 15'h0000, 3'b111);
    wait_vld(lat, busy);
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL full_latency: got %0d want 7", lat); end
    n_cmp++; if (busy !== 7) begin n_err++; $display("FAIL full_busy_cycles: got %0d want 7", busy); end
    n_cmp++;
    if ({u_if.o_cube0, u_if.o_cube1, u_if.o_cube2} !== {14'h1000, 14'h0200, 14'h0000}) begin
      n_err++;
      $display("FAIL full_cubes: got %h %h %h want 1000 0200 0000", u_if.o_cube0, u_if.o_cube1, u_if.o_cube2);
    end
    step();
    n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL full_return_idle: got %0d want %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_overflow();
    int lat, busy;
    u_if.i_rdy = 1'b1;
    send(15'h7FFF, 15'h1111, 15'h2222, 3'b001);
    wait_vld(lat, busy);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL ovf_latency: got %0d want 3", lat); end
    n_cmp++;
    if ({u_if.o_cube0, u_if.o_cube1, u_if.o_cube2} !== {14'h3FFD, 14'h0000, 14'h0000}) begin
      n_err++;
      $display("FAIL ovf_cubes: got %h %h %h want 3ffd 0000 0000", u_if.o_cube0, u_if.o_cube1, u_if.o_cube2);
    end
    step();
  endtask

  task automatic test_mask_skip();
    int lat, busy;
    u_if.i_rdy = 1'b1;
    send(15'h1234, 15'h5678, 15'h4000, 3'b100);
    u_if.i_op2  = 15'h7FFF;
    u_if.i_mask = 3'b111;
    wait_vld(lat, busy);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL skip100_latency: got %0d want 3", lat); end
    n_cmp++;
    if ({u_if.o_cube0, u_if.o_cube1, u_if.o_cube2} !== {14'h0000, 14'h0000, 14'h1000}) begin
      n_err++;
      $display("FAIL skip100_cubes: got %h %h %h want 0000 0000 1000", u_if.o_cube0, u_if.o_cube1, u_if.o_cube2);
    end
    step();
    send(15'h4000, 15'h4000, 15'h4000, 3'b000);
    wait_vld(lat, busy);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL skip000_latency: got %0d want 1", lat); end
    n_cmp++;
    if ({u_if.o_cube0, u_if.o_cube1, u_if.o_cube2} !== 42'd0) begin
      n_err++;
      $display("FAIL skip000_cubes: got %h %h %h want 0 0 0", u_if.o_cube0, u_if.o_cube1, u_if.o_cube2);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, busy;
    logic [41:0] exp;
    u_if.i_rdy = 1'b0;
    send(15'h4000, 15'h4000, 15'h2000, 3'b111);
    exp_q.push_back({14'h1000, 14'h1000, 14'h0200});
    wait_vld(lat, busy);
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 7", lat); end
    exp = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (u_if.o_vld !== 1'b1) begin n_err++; $display("FAIL stall_o_vld[%0d]: got %b want 1", i, u_if.o_vld); end
      n_cmp++; if (u_if.o_rdy !== 1'b0) begin n_err++; $display("FAIL stall_o_rdy[%0d]: got %b want 0", i, u_if.o_rdy); end
      n_cmp++;
      if ({u_if.o_cube0, u_if.o_cube1, u_if.o_cube2} !== exp) begin
        n_err++;
        $display("FAIL stall_cubes[%0d]: got %h %h %h want %h", i, u_if.o_cube0, u_if.o_cube1, u_if.o_cube2, exp);
      end
      step();
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if ({u_if.o_cube0, u_if.o_cube1, u_if.o_cube2} !== exp) begin
      n_err++;
      $display("FAIL b2b_first_cubes: got %h %h %h want %h", u_if.o_cube0, u_if.o_cube1, u_if.o_cube2, exp);
    end
    u_if.i_rdy  = 1'b1;
    u_if.i_op0  = 15'h2000;
    u_if.i_op1  = 15'h7FFF;
    u_if.i_op2  = 15'h0000;
    u_if.i_mask = 3'b111;
    u_if.i_vld  = 1'b1;
    #1;
    n_cmp++; if (u_if.o_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_comb_rdy: got %b want 1", u_if.o_rdy); end
    exp_q.push_back({14'h0200, 14'h3FFD, 14'h0000});
    send(15'h2000, 15'h7FFF, 15'h0000, 3'b111);
    n_cmp++; if (dbg_state !== S_SQ) begin n_err++; $display("FAIL b2b_state_after_handoff: got %0d want %0d", dbg_state, S_SQ); end
    wait_vld(lat, busy);
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL b2b_second_latency: got %0d want 7", lat); end
    exp = exp_q.pop_front();
    n_cmp++;
    if ({u_if.o_cube0, u_if.o_cube1, u_if.o_cube2} !== exp) begin
      n_err++;
      $display("FAIL b2b_second_cubes: got %h %h %h want %h", u_if.o_cube0, u_if.o_cube1, u_if.o_cube2, exp);
    end
    step();
  endtask

  task automatic test_mid_reset();
    int lat, busy;
    logic seen;
    u_if.i_rdy = 1'b1;
    send(15'h4000, 15'h2000, 15'h0000, 3'b111);
    step();
    step();
    rst = 1'b1;
    step();
    n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, S_IDLE); end
    n_cmp++; if (u_if.o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_o_busy: got %b want 0", u_if.o_busy); end
    rst  = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      if (u_if.o_vld) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_vld: got %b want 0", seen); end
    send(15'h7FFF, 15'h4000, 15'h2000, 3'b011);
    wait_vld(lat, busy);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL midrst_fresh_latency: got %0d want 5", lat); end
    n_cmp++;
    if ({u_if.o_cube0, u_if.o_cube1, u_if.o_cube2} !== {14'h3FFD, 14'h1000, 14'h0000}) begin
      n_err++;
      $display("FAIL midrst_fresh_cubes: got %h %h %h want 3ffd 1000 0000", u_if.o_cube0, u_if.o_cube1, u_if.o_cube2);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_overflow();
    test_mask_skip();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
